adder_rr_sched: RTL and testbench
=================================

Name: adder_rr_sched

Overview:
- Round-robin scheduler that shares one `sync_adder` instance (1-cycle registered latency; ports `enable`/`a`/`b` in, `sum`/`valid` out) among NREQ requesters.
- Accepts operand pairs over per-requester valid/ready handshakes and issues one addition at a time.
- Returns each result with the originating requester ID over a single valid/ready response channel.
- Sits between the requester blocks and the shared adder.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 8, operand width; must equal the adder's WIDTH.
- IDW, 2, requester-ID width; equals $clog2(NREQ).
- TIMEOUT, 16, max WAIT cycles before error response (used only with optional feature).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept; at most one bit high.
- req_a  in  NREQ*WIDTH  packed operand A; requester i at [i*WIDTH +: WIDTH].
- req_b  in  NREQ*WIDTH  packed operand B; same packing as req_a.
- resp_valid  out  1  result valid.
- resp_ready  in  1  consumer accepts result.
- resp_id  out  IDW  requester index owning the result.
- resp_sum  out  WIDTH+1  result including carry bit.
- add_en  out  1  drives adder `enable`.
- add_a  out  WIDTH  drives adder `a`.
- add_b  out  WIDTH  drives adder `b`.
- add_sum  in  WIDTH+1  from adder `sum`.
- add_valid  in  1  from adder `valid`.

Behaviour:
- Clock/reset: one clock `clk`; `rst` is asynchronous, active-high. While `rst`=1:
  - state=IDLE, rr_ptr=0.
  - req_ready, resp_valid, resp_id, resp_sum, add_en, add_a, add_b all 0.
  - Any in-flight transaction is discarded; no response is ever produced for it.
- FSM states: IDLE, ISSUE, WAIT, RESP; one transaction in flight at a time.
- IDLE:
  - Grant g = first i with req_valid[i]=1, scanning rr_ptr, rr_ptr+1, ... wrapping modulo NREQ.
  - req_ready[g]=1 combinationally in this cycle only.
  - On handshake, latch req_a/req_b slice g into add_a/add_b and g into cur_id; go to ISSUE.
  - If no req_valid bit is set, stay in IDLE with all req_ready=0.
- ISSUE: add_en=1 for exactly one cycle; add_a/add_b stable; go to WAIT.
- WAIT:
  - add_en=0.
  - When add_valid=1: capture add_sum into resp_sum, cur_id into resp_id; go to RESP.
  - add_valid is ignored in every other state.
- RESP:
  - resp_valid=1; resp_id and resp_sum held stable until resp_ready=1.
  - On handshake: resp_valid=0 next cycle, rr_ptr=(cur_id+1) mod NREQ, go to IDLE.
  - A requester asserting req_valid during RESP is not accepted until IDLE.
- Latency: request accepted at cycle T → add_en high T+1 → add_valid T+2 → resp_valid T+3 (resp_ready held high).
- Throughput: one result per 4 cycles.
- Arithmetic: no truncation; resp_sum = a+b in WIDTH+1 bits (255+255=510).
- add_a/add_b retain the last issued operands outside ISSUE.
- Requester handshake rules:
  - A requester must hold req_valid and its operands stable until req_ready is seen.
  - Dropping req_valid before grant withdraws the request; no error is flagged.
- Fairness: a requester that keeps req_valid asserted is served within NREQ transactions.

Optional Feature:
- Macro: ADDER_TIMEOUT_EN.
- Defined:
  - Adds output `resp_err` (1 bit); reset 0.
  - A WAIT-cycle counter resets on entry to WAIT.
  - If add_valid is not seen within TIMEOUT cycles: go to RESP with resp_err=1, resp_sum=0, resp_id=cur_id.
  - Normal responses drive resp_err=0.
- Not defined: no `resp_err` port and no counter; WAIT waits indefinitely for add_valid.

Test Plan:
- Reset, then single request: req1 a=5 b=55 → req_ready[1] at T, add_en at T+1, resp_valid T+3 with resp_id=1, resp_sum=60.
- Overflow: req0 a=200 b=100, then a=255 b=255 → resp_sum=300, then 510; carry bit set both times.
- Contention, all four requesters valid continuously with distinct operands (req i: a=i, b=10) → grant order 0,1,2,3,0; resp_sum 10,11,12,13,10.
- Response backpressure: hold resp_ready=0 for 5 cycles in RESP → resp_valid, resp_id, resp_sum stable; no req_ready or add_en asserted until release.
- Async reset asserted in WAIT (between add_en and add_valid) → all outputs 0 immediately; no resp_valid after release; next grant goes to requester 0.
- ADDER_TIMEOUT_EN, TIMEOUT=16, adder valid tied 0 → resp_valid with resp_err=1, resp_sum=0 exactly 16 WAIT cycles after add_en.

Source files
------------

// File: rtl/adder_rr_sched.sv
// adder_rr_sched: round-robin scheduler sharing one registered adder among NREQ requesters.
// Optional ADDER_TIMEOUT_EN adds resp_err and a watchdog on the adder result.
module adder_rr_sched #(
  parameter int NREQ    = 4,
  parameter int WIDTH   = 8,
  parameter int IDW     = 2,
  parameter int TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [IDW-1:0]        resp_id,
  output logic [WIDTH:0]        resp_sum,
`ifdef ADDER_TIMEOUT_EN
  output logic                  resp_err,
`endif
  output logic                  add_en,
  output logic [WIDTH-1:0]      add_a,
  output logic [WIDTH-1:0]      add_b,
  input  logic [WIDTH:0]        add_sum,
  input  logic                  add_valid
);

  if (NREQ < 2 || NREQ > 8 || IDW != $clog2(NREQ) || TIMEOUT < 1)
  begin : g_param_chk
    $error("adder_rr_sched: bad parameters");
  end

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_e;

  state_e           state_q, state_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]   cur_id_q, cur_id_d;
  logic [IDW-1:0]   resp_id_q, resp_id_d;
  logic [WIDTH-1:0] add_a_q, add_a_d;
  logic [WIDTH-1:0] add_b_q, add_b_d;
  logic [WIDTH:0]   resp_sum_q, resp_sum_d;

`ifdef ADDER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             resp_err_q, resp_err_d;
`endif

  logic             gnt_any;
  logic [IDW-1:0]   gnt_id;
  logic [IDW-1:0]   scan_idx;

  // Descending scan: the last hit is the one closest to rr_ptr.
  always_comb begin
    gnt_any  = 1'b0;
    gnt_id   = '0;
    scan_idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      scan_idx = IDW'((int'(rr_ptr_q) + k) % NREQ);
      if (req_valid[scan_idx]) begin
        gnt_any = 1'b1;
        gnt_id  = scan_idx;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state_q == IDLE && gnt_any && !rst) begin
      req_ready[gnt_id] = 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    cur_id_d   = cur_id_q;
    resp_id_d  = resp_id_q;
    add_a_d    = add_a_q;
    add_b_d    = add_b_q;
    resp_sum_d = resp_sum_q;
`ifdef ADDER_TIMEOUT_EN
    cnt_d      = cnt_q;
    resp_err_d = resp_err_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (gnt_any) begin
          cur_id_d = gnt_id;
          add_a_d  = req_a[int'(gnt_id)*WIDTH +: WIDTH];
          add_b_d  = req_b[int'(gnt_id)*WIDTH +: WIDTH];
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
`ifdef ADDER_TIMEOUT_EN
        cnt_d   = '0;
`endif
        state_d = WAIT;
      end
      WAIT: begin
        if (add_valid) begin
          resp_sum_d = add_sum;
          resp_id_d  = cur_id_q;
`ifdef ADDER_TIMEOUT_EN
          resp_err_d = 1'b0;
`endif
          state_d    = RESP;
        end
`ifdef ADDER_TIMEOUT_EN
        else if (cnt_q == CW'(TIMEOUT - 1)) begin
          resp_sum_d = '0;
          resp_id_d  = cur_id_q;
          resp_err_d = 1'b1;
          state_d    = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      RESP: begin
        if (resp_ready) begin
          rr_ptr_d = (cur_id_q == IDW'(NREQ - 1)) ? '0 : cur_id_q + 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      cur_id_q   <= '0;
      resp_id_q  <= '0;
      add_a_q    <= '0;
      add_b_q    <= '0;
      resp_sum_q <= '0;
`ifdef ADDER_TIMEOUT_EN
      cnt_q      <= '0;
      resp_err_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      cur_id_q   <= cur_id_d;
      resp_id_q  <= resp_id_d;
      add_a_q    <= add_a_d;
      add_b_q    <= add_b_d;
      resp_sum_q <= resp_sum_d;
`ifdef ADDER_TIMEOUT_EN
      cnt_q      <= cnt_d;
      resp_err_q <= resp_err_d;
`endif
    end
  end

  assign add_en     = (state_q == ISSUE);
  assign resp_valid = (state_q == RESP);
  assign add_a      = add_a_q;
  assign add_b      = add_b_q;
  assign resp_id    = resp_id_q;
  assign resp_sum   = resp_sum_q;
`ifdef ADDER_TIMEOUT_EN
  assign resp_err   = resp_err_q;
`endif

endmodule

// File: tb/tb_adder_rr_sched.sv
// tb_adder_rr_sched: directed and randomized checks of the round-robin adder scheduler.
// A behavioural 1-cycle adder closes the loop around the DUT.
module tb_adder_rr_sched;
  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int IDW   = 2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [IDW-1:0]        resp_id;
  logic [WIDTH:0]        resp_sum;
  logic                  add_en;
  logic [WIDTH-1:0]      add_a;
  logic [WIDTH-1:0]      add_b;
  logic [WIDTH:0]        add_sum = '0;
  logic                  add_valid = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    add_valid <= add_en;
    if (add_en) add_sum <= {1'b0, add_a} + {1'b0, add_b};
  end

  adder_rr_sched #(
    .NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW), .TIMEOUT(16)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_sum(resp_sum),
    .add_en(add_en), .add_a(add_a), .add_b(add_b),
    .add_sum(add_sum), .add_valid(add_valid)
  );

  task automatic put_req(input int i, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b);
    req_valid[i] = 1'b1;
    req_a[i*WIDTH +: WIDTH] = a;
    req_b[i*WIDTH +: WIDTH] = b;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req_valid = '0;
    resp_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = '1;
    req_a = '1;
    req_b = '1;
    resp_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (req_ready !== '0) begin
      errors++;
      $display("FAIL reset_req_ready: got %b want 0", req_ready);
    end
    checks++;
    if ({resp_valid, resp_id, resp_sum, add_en, add_a, add_b} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: rv=%b id=%0d sum=%0d en=%b a=%0d b=%0d want all 0",
               resp_valid, resp_id, resp_sum, add_en, add_a, add_b);
    end
    @(negedge clk);
    rst = 1'b0;
    resp_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL reset_rr_ptr: got %b want 0001", req_ready);
    end
    req_valid = '0;
  endtask

  task automatic test_single();
    @(negedge clk);
    put_req(1, 8'd5, 8'd55);
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin
      errors++;
      $display("FAIL single_grant: got %b want 0010", req_ready);
    end
    @(negedge clk);
    req_valid = '0;
    #1;
    checks++;
    if ({add_en, add_a, add_b} !== {1'b1, 8'd5, 8'd55}) begin
      errors++;
      $display("FAIL single_issue: en=%b a=%0d b=%0d want 1 5 55", add_en, add_a, add_b);
    end
    @(negedge clk);
    #1;
    checks++;
    if ({add_en, resp_valid} !== 2'b00) begin
      errors++;
      $display("FAIL single_wait: en=%b rv=%b want 0 0", add_en, resp_valid);
    end
    @(negedge clk);
    #1;
    checks++;
    if ({resp_valid, resp_id, resp_sum} !== {1'b1, 2'd1, 9'd60}) begin
      errors++;
      $display("FAIL single_resp: rv=%b id=%0d sum=%0d want 1 1 60",
               resp_valid, resp_id, resp_sum);
    end
    @(negedge clk);
    #1;
    checks++;
    if (resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_release: rv=%b want 0", resp_valid);
    end
  endtask

  task automatic test_overflow();
    int va[2] = '{200, 255};
    int vb[2] = '{100, 255};
    for (int t = 0; t < 2; t++) begin
      int n;
      int want;
      want = va[t] + vb[t];
      @(negedge clk);
      put_req(0, WIDTH'(va[t]), WIDTH'(vb[t]));
      #1;
      checks++;
      if (req_ready !== 4'b0001) begin
        errors++;
        $display("FAIL ovf_grant%0d: got %b want 0001", t, req_ready);
      end
      for (n = 0; n < 8; n++) begin
        @(negedge clk);
        req_valid = '0;
        #1;
        if (resp_valid) break;
      end
      checks++;
      if (resp_valid !== 1'b1 || resp_sum !== (WIDTH+1)'(want) ||
          resp_sum[WIDTH] !== 1'b1 || resp_id !== '0) begin
        errors++;
        $display("FAIL ovf_sum%0d: rv=%b id=%0d sum=%0d want 1 0 %0d",
                 t, resp_valid, resp_id, resp_sum, want);
      end
    end
  endtask

  task automatic test_contention();
    int rr;
    int g;
    int n;
    do_reset();
    rr = 0;
    for (int i = 0; i < NREQ; i++) put_req(i, WIDTH'(i), 8'd10);
    #1;
    for (int t = 0; t < 5; t++) begin
      for (n = 0; n < 8; n++) begin
        if (req_ready != '0) break;
        @(negedge clk);
        #1;
      end
      g = rr;
      checks++;
      if (req_ready !== NREQ'(1 << g)) begin
        errors++;
        $display("FAIL cont_grant%0d: got %b want id %0d", t, req_ready, g);
      end
      for (n = 0; n < 8; n++) begin
        @(negedge clk);
        #1;
        if (resp_valid) break;
      end
      checks++;
      if (resp_valid !== 1'b1 || resp_id !== IDW'(g) ||
          resp_sum !== (WIDTH+1)'(g + 10)) begin
        errors++;
        $display("FAIL cont_resp%0d: rv=%b id=%0d sum=%0d want 1 %0d %0d",
                 t, resp_valid, resp_id, resp_sum, g, g + 10);
      end
      rr = (g + 1) % NREQ;
    end
    req_valid = '0;
  endtask

  task automatic test_backpressure();
    logic [IDW-1:0] hid;
    logic [WIDTH:0] hsum;
    int n;
    @(negedge clk);
    resp_ready = 1'b0;
    put_req(2, 8'd77, 8'd88);
    #1;
    checks++;
    if (req_ready !== 4'b0100) begin
      errors++;
      $display("FAIL bp_grant: got %b want 0100", req_ready);
    end
    for (n = 0; n < 8; n++) begin
      @(negedge clk);
      req_valid[2] = 1'b0;
      put_req(3, 8'd1, 8'd2);
      #1;
      if (resp_valid) break;
    end
    hid = resp_id;
    hsum = resp_sum;
    checks++;
    if (resp_valid !== 1'b1 || hid !== 2'd2 || hsum !== 9'd165) begin
      errors++;
      $display("FAIL bp_resp: rv=%b id=%0d sum=%0d want 1 2 165", resp_valid, hid, hsum);
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #1;
      checks++;
      if (resp_valid !== 1'b1 || resp_id !== hid || resp_sum !== hsum ||
          req_ready !== '0 || add_en !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold%0d: rv=%b id=%0d sum=%0d rdy=%b en=%b want 1 2 165 0 0",
                 c, resp_valid, resp_id, resp_sum, req_ready, add_en);
      end
    end
    @(negedge clk);
    resp_ready = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 4'b1000) begin
      errors++;
      $display("FAIL bp_release: rv=%b rdy=%b want 0 1000", resp_valid, req_ready);
    end
    req_valid = '0;
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    put_req(1, 8'd9, 8'd9);
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin
      errors++;
      $display("FAIL ar_grant: got %b want 0010", req_ready);
    end
    @(negedge clk);
    req_valid = '0;
    #1;
    checks++;
    if (add_en !== 1'b1) begin
      errors++;
      $display("FAIL ar_issue: en=%b want 1", add_en);
    end
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if ({req_ready, resp_valid, resp_id, resp_sum, add_en, add_a, add_b} !== '0) begin
      errors++;
      $display("FAIL ar_clear: rdy=%b rv=%b id=%0d sum=%0d en=%b a=%0d b=%0d want all 0",
               req_ready, resp_valid, resp_id, resp_sum, add_en, add_a, add_b);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      #1;
      checks++;
      if (resp_valid !== 1'b0 || add_en !== 1'b0) begin
        errors++;
        $display("FAIL ar_ghost%0d: rv=%b en=%b want 0 0", c, resp_valid, add_en);
      end
    end
    @(negedge clk);
    for (int i = 0; i < NREQ; i++) put_req(i, 8'd3, 8'd4);
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL ar_regrant: got %b want 0001", req_ready);
    end
    req_valid = '0;
  endtask

  // Transaction-level model: one job at a time, add_en one cycle after
  // acceptance, response from three cycles after acceptance until taken.
  task automatic test_random();
    bit               pend[NREQ];
    logic [WIDTH-1:0] pa[NREQ];
    logic [WIDTH-1:0] pb[NREQ];
    bit               busy;
    int               acc_cyc, cur, es, rr, g, done;
    logic [WIDTH-1:0] ea, eb;
    logic [NREQ-1:0]  exp_rdy;
    bit               exp_en, exp_rv;
    do_reset();
    busy = 0; rr = 0; done = 0; acc_cyc = 0; cur = 0; es = 0;
    ea = '0; eb = '0;
    for (int i = 0; i < NREQ; i++) begin
      pend[i] = 0; pa[i] = '0; pb[i] = '0;
    end
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i] && $urandom_range(0, 3) == 0) begin
          pend[i] = 1;
          pa[i] = WIDTH'($urandom);
          pb[i] = WIDTH'($urandom);
        end else if (pend[i] && $urandom_range(0, 31) == 0) begin
          pend[i] = 0;
        end
        req_valid[i] = pend[i];
        req_a[i*WIDTH +: WIDTH] = pa[i];
        req_b[i*WIDTH +: WIDTH] = pb[i];
      end
      resp_ready = ($urandom_range(0, 2) != 0);
      #1;
      g = -1;
      exp_rdy = '0;
      if (!busy) begin
        for (int k = 0; k < NREQ; k++) begin
          if (pend[(rr + k) % NREQ]) begin
            g = (rr + k) % NREQ;
            break;
          end
        end
      end
      if (g >= 0) exp_rdy[g] = 1'b1;
      exp_en = busy && (cyc == acc_cyc + 1);
      exp_rv = busy && (cyc >= acc_cyc + 3);
      checks++;
      if (req_ready !== exp_rdy) begin
        errors++;
        $display("FAIL rnd_ready c%0d: got %b want %b", cyc, req_ready, exp_rdy);
      end
      checks++;
      if (add_en !== exp_en || (exp_en && (add_a !== ea || add_b !== eb))) begin
        errors++;
        $display("FAIL rnd_issue c%0d: en=%b a=%0d b=%0d want %b %0d %0d",
                 cyc, add_en, add_a, add_b, exp_en, ea, eb);
      end
      checks++;
      if (resp_valid !== exp_rv ||
          (exp_rv && (resp_id !== IDW'(cur) || resp_sum !== (WIDTH+1)'(es)))) begin
        errors++;
        $display("FAIL rnd_resp c%0d: rv=%b id=%0d sum=%0d want %b %0d %0d",
                 cyc, resp_valid, resp_id, resp_sum, exp_rv, cur, es);
      end
      if (g >= 0) begin
        busy = 1;
        acc_cyc = cyc;
        cur = g;
        ea = pa[g];
        eb = pb[g];
        es = int'(pa[g]) + int'(pb[g]);
        pend[g] = 0;
      end else if (exp_rv && resp_ready) begin
        busy = 0;
        rr = (cur + 1) % NREQ;
        done++;
      end
    end
    checks++;
    if (done < 20) begin
      errors++;
      $display("FAIL rnd_progress: completed %0d want >= 20", done);
    end
    req_valid = '0;
    resp_ready = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    resp_ready = 1'b1;
    test_reset();
    test_single();
    test_overflow();
    test_contention();
    test_backpressure();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
